alu_6bit: RTL and testbench
===========================

ALU_6BIT -- requirements
Module: alu_6bit

Interface
REQ-001 Parameter WIDTH, default 6, operand/result width; only 6 is required to be supported.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  A/B/Op are sampled on this edge when high.
REQ-006 A  input  6  operand A, unsigned (two's complement for flag purposes).
REQ-007 B  input  6  operand B.
REQ-008 Op  input  2  operation select.
REQ-009 R  output  6  registered result.
REQ-010 out_valid  output  1  high for one cycle when R holds a new result.
REQ-011 flags  output  4  {carry, overflow, negative, zero}; present only when ALU6BIT_FLAGS_EN is defined.

Function
REQ-012 Op=0 SHALL compute R = (A + B) mod 64.
REQ-013 Op=1 SHALL compute R = (A - B) mod 64 (two's-complement wrap).
REQ-014 Op=2 SHALL compute R = A AND B, bitwise.
REQ-015 Op=3 SHALL compute R = A OR B, bitwise.
REQ-016 Latency SHALL be 1 cycle: inputs sampled at edge N with in_valid=1 appear on R with out_valid=1 after edge N.
REQ-017 With in_valid=0 at an edge, R SHALL hold its previous value and out_valid SHALL be 0 after that edge.
REQ-018 Back-to-back in_valid SHALL produce one result per cycle with no bubbles; no backpressure exists.
REQ-019 Carry: add -> bit 6 of the 7-bit sum; sub -> borrow (1 when A < B unsigned); logic ops -> 0.
REQ-020 Overflow: add -> operands same sign and result sign differs; sub -> operands differ in sign and result sign differs from A; logic ops -> 0.
REQ-021 Negative SHALL equal R[5]; zero SHALL be 1 when R == 0; both are registered with R.
REQ-022 No X propagation: every Op encoding is defined; no latches.

Reset
REQ-023 rst=1 at an edge SHALL force R=0, out_valid=0, flags=0, overriding in_valid in the same cycle.
REQ-024 A reset asserted while a result is pending SHALL discard that result; the first result after reset SHALL come from the first in_valid edge with rst=0.

Configuration
REQ-025 Macro ALU6BIT_FLAGS_EN defined: the flags port and its registers exist per REQ-019..021.
REQ-026 Macro ALU6BIT_FLAGS_EN undefined: no flags port and no flag logic; R/out_valid behaviour is identical.

Structure
REQ-027 Shared package alu_6bit_pkg SHALL hold the Op encoding enum (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3), the WIDTH constant, and the flag bit-index constants.
REQ-028 Combinational datapath SHALL be one sub-module alu_6bit_core (A, B, Op -> result, carry, overflow); the top level adds the registers and valid logic.

Verification
REQ-029 A=4, B=3, Op=0,1,2,3 back-to-back -> R=7, 1, 0, 7 on successive cycles, out_valid high each cycle.
REQ-030 A=14, B=5, Op=0,1,2,3 -> R=19, 9, 4, 15.
REQ-031 A=2, B=10, Op=0,1,2,3 -> R=12, 56 (carry/borrow=1, negative=1), 2, 10.
REQ-032 A=63, B=1, Op=0 -> R=0, carry=1, zero=1; A=31, B=1, Op=0 -> R=32, overflow=1, negative=1.
REQ-033 in_valid=1 with rst=1 in the same cycle -> R=0 and out_valid=0; then in_valid=0 for 3 cycles -> R holds and out_valid stays 0.
REQ-034 Repeat REQ-029..031 with ALU6BIT_FLAGS_EN undefined -> identical R and out_valid, and no flags port.

Source files
------------

// File: rtl/alu_6bit_pkg.sv
// Shared definitions for the 6-bit ALU: operation encoding, width and flag bit positions.
package alu_6bit_pkg;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 4;

    // flags = {carry, overflow, negative, zero}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

endpackage

// File: rtl/alu_6bit_core.sv
// Combinational ALU datapath: result plus carry/borrow and signed overflow.
module alu_6bit_core
    import alu_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = alu_6bit_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c,
    output logic             overflow_c
);

    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] diff_c;

    // One extra bit holds the carry out of the add and the borrow of the subtract
    assign sum_c  = {1'b0, a} + {1'b0, b};
    assign diff_c = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_c   = '0;
        carry_c    = 1'b0;
        overflow_c = 1'b0;
        case (op)
            OP_ADD: begin
                result_c   = sum_c[WIDTH-1:0];
                carry_c    = sum_c[WIDTH];
                overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result_c   = diff_c[WIDTH-1:0];
                carry_c    = diff_c[WIDTH];
                overflow_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_6bit.sv
// Registered 6-bit ALU with one-cycle latency and a valid strobe.
// Define ALU6BIT_FLAGS_EN to add the registered {carry, overflow, negative, zero} flags port.
module alu_6bit
    import alu_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = alu_6bit_pkg::WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_W-1:0]     Op,
    output logic [WIDTH-1:0]    R,
    output logic                out_valid
`ifdef ALU6BIT_FLAGS_EN
    ,
    output logic [FLAG_W-1:0]   flags
`endif
);

    logic [WIDTH-1:0] result_c;
    logic             carry_c;
    logic             overflow_c;

    alu_6bit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a          (A),
        .b          (B),
        .op         (op_e'(Op)),
        .result_c   (result_c),
        .carry_c    (carry_c),
        .overflow_c (overflow_c)
    );

    // Result and strobe; reset wins over a same-cycle in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            R         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R <= result_c;
            end
        end
    end

`ifdef ALU6BIT_FLAGS_EN
    // Flags update only together with R
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (in_valid) begin
            flags[FLAG_C] <= carry_c;
            flags[FLAG_V] <= overflow_c;
            flags[FLAG_N] <= result_c[WIDTH-1];
            flags[FLAG_Z] <= (result_c == '0);
        end
    end
`else
    logic unused_flag_bits;
    assign unused_flag_bits = carry_c ^ overflow_c;
`endif

endmodule

// File: tb/tb_alu_6bit.sv
// Self-checking bench for alu_6bit: arithmetic reference model plus directed literal vectors.
// Builds with or without ALU6BIT_FLAGS_EN, matching the design's configuration.
module tb_alu_6bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] A;
    logic [5:0] B;
    logic [1:0] Op;
    logic [5:0] R;
    logic       out_valid;
`ifdef ALU6BIT_FLAGS_EN
    logic [3:0] flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_6bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .R         (R),
        .out_valid (out_valid)
`ifdef ALU6BIT_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on sampled operands
    int          exp_r;
    bit          exp_v;
    logic [3:0]  exp_f;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        int a, b, sa, sb, full, sfull, r;
        bit c, v;
        if (rst) begin
            exp_r    = 0;
            exp_v    = 1'b0;
            exp_f    = 4'd0;
            model_ok = 1'b1;
        end else begin
            exp_v = in_valid;
            if (in_valid) begin
                a  = int'(A);
                b  = int'(B);
                sa = (a >= 32) ? a - 64 : a;
                sb = (b >= 32) ? b - 64 : b;
                c  = 1'b0;
                v  = 1'b0;
                case (int'(Op))
                    0: begin
                        full  = a + b;
                        sfull = sa + sb;
                        r     = full % 64;
                        c     = (full >= 64);
                        v     = (sfull > 31) || (sfull < -32);
                    end
                    1: begin
                        full  = a - b;
                        sfull = sa - sb;
                        r     = (full + 64) % 64;
                        c     = (a < b);
                        v     = (sfull > 31) || (sfull < -32);
                    end
                    2: r = a & b;
                    default: r = a | b;
                endcase
                exp_r = r;
                exp_f = {c, v, r >= 32, r == 0};
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("R_model", 32'(R), 32'(exp_r));
            check("out_valid_model", 32'(out_valid), 32'(exp_v));
`ifdef ALU6BIT_FLAGS_EN
            check("flags_model", 32'(flags), 32'(exp_f));
`endif
        end
    end

    task automatic drive(input int a, input int b, input int op, input bit v, input bit r);
        @(negedge clk);
        A        = 6'(a);
        B        = 6'(b);
        Op       = 2'(op);
        in_valid = v;
        rst      = r;
    endtask

    task automatic apply_chk(input string name, input int a, input int b, input int op,
                             input int er, input bit chk_f, input logic [3:0] ef);
        drive(a, b, op, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check({name, "_R"}, 32'(R), 32'(er));
        check({name, "_valid"}, 32'(out_valid), 32'd1);
`ifdef ALU6BIT_FLAGS_EN
        if (chk_f) check({name, "_flags"}, 32'(flags), 32'(ef));
`else
        if (chk_f && ef === 4'bxxxx) check({name, "_flags"}, 32'(ef), 32'd0);
`endif
    endtask

    task automatic idle_chk(input string name, input int er);
        drive(0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check({name, "_R"}, 32'(R), 32'(er));
        check({name, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Op       = '0;
        drive(0, 0, 0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("reset_R", 32'(R), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
`ifdef ALU6BIT_FLAGS_EN
        check("reset_flags", 32'(flags), 32'd0);
`endif

        // Back-to-back directed vectors; flags given as {c, v, n, z}
        apply_chk("add_4_3",   4,  3, 0,  7, 1'b1, 4'b0000);
        apply_chk("sub_4_3",   4,  3, 1,  1, 1'b1, 4'b0000);
        apply_chk("and_4_3",   4,  3, 2,  0, 1'b1, 4'b0001);
        apply_chk("or_4_3",    4,  3, 3,  7, 1'b1, 4'b0000);
        apply_chk("add_14_5", 14,  5, 0, 19, 1'b0, 4'b0000);
        apply_chk("sub_14_5", 14,  5, 1,  9, 1'b0, 4'b0000);
        apply_chk("and_14_5", 14,  5, 2,  4, 1'b0, 4'b0000);
        apply_chk("or_14_5",  14,  5, 3, 15, 1'b0, 4'b0000);
        apply_chk("add_2_10",  2, 10, 0, 12, 1'b1, 4'b0000);
        apply_chk("sub_2_10",  2, 10, 1, 56, 1'b1, 4'b1010);
        apply_chk("and_2_10",  2, 10, 2,  2, 1'b1, 4'b0000);
        apply_chk("or_2_10",   2, 10, 3, 10, 1'b1, 4'b0000);
        apply_chk("add_63_1", 63,  1, 0,  0, 1'b1, 4'b1001);
        apply_chk("add_31_1", 31,  1, 0, 32, 1'b1, 4'b0110);
        idle_chk("hold_after_add", 32);

        // Reset overrides a same-cycle in_valid, then R holds through idle cycles
        drive(5, 5, 0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("rst_vs_valid_R", 32'(R), 32'd0);
        check("rst_vs_valid_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) idle_chk("idle_after_rst", 0);

        // Randomized traffic with occasional resets, checked by the model
        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(3)),
                  ($urandom_range(99) < 75), ($urandom_range(99) < 3));
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
